// File: rtl/img_accel_pkg.sv
// ============================================================================
// Module   : img_accel_pkg
// Summary  : Shared types and widths for the image accelerator input path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package img_accel_pkg;

    localparam int ADDR_W = 12;
    localparam int WORD_W = 108;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Summary  : Single-clock FIFO with count; head word readable one cycle after write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 108,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             w_rd;

    // Caller guarantees no write while full unless the same cycle reads.
    assign w_rd    = rd_en && !empty;
    assign full    = (r_count == c_cw'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({wr_en, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/input_read_sequencer.sv
// ============================================================================
// Module   : input_read_sequencer
// Summary  : Raster-scan read issuer with credit-limited response FIFO and
//            eol/last tagged output stream. READ_SEQ_PERF_EN adds stall counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_read_sequencer
    import img_accel_pkg::*;
#(
    parameter int ADD_SIZE   = ADDR_W,
    parameter int DATA_SIZE  = WORD_W,
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADD_SIZE-1:0]  base_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_req,
    output logic [ADD_SIZE-1:0]  rd_addr,
    input  logic                 rd_ready,
    input  logic                 rsp_valid,
    input  logic [DATA_SIZE-1:0] rsp_data,
    output logic                 out_valid,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_eol,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 rsp_err
`ifdef READ_SEQ_PERF_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          bp_cycles
`endif
);

    localparam int c_col_w = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_row_w = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_col_w-1:0] c_last_col = c_col_w'(IMG_W - 1);
    localparam logic [c_row_w-1:0] c_last_row = c_row_w'(IMG_H - 1);

    seq_state_t          r_state;
    seq_state_t          w_state_next;
    logic [ADD_SIZE-1:0] r_addr;
    logic [c_col_w-1:0]  r_col;
    logic [c_row_w-1:0]  r_row;
    logic [c_col_w-1:0]  r_out_col;
    logic [c_row_w-1:0]  r_out_row;
    logic [c_cnt_w-1:0]  r_inflight;
    logic                r_rsp_err;

    logic                w_start_acc;
    logic                w_credit_ok;
    logic                w_acc;
    logic                w_issue_last;
    logic                w_rsp_ok;
    logic                w_out_hs;
    logic                w_fifo_wr;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [c_cnt_w-1:0]  w_fifo_count;

    // Every outstanding read owns a FIFO slot, so the FIFO can never overflow.
    assign w_credit_ok  = ({1'b0, r_inflight} + {1'b0, w_fifo_count}) < (c_cnt_w + 1)'(FIFO_DEPTH);
    assign w_start_acc  = (r_state == IDLE) && start;
    assign rd_req       = (r_state == ISSUE) && w_credit_ok;
    assign w_acc        = rd_req && rd_ready;
    assign w_issue_last = (r_col == c_last_col) && (r_row == c_last_row);
    assign w_rsp_ok     = rsp_valid && (r_inflight != '0);
    assign w_out_hs     = out_valid && out_ready;
    assign w_fifo_wr    = w_rsp_ok && (!w_fifo_full || w_out_hs);

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign rd_addr   = r_addr;
    assign out_valid = !w_fifo_empty;
    assign out_eol   = out_valid && (r_out_col == c_last_col);
    assign out_last  = out_eol && (r_out_row == c_last_row);
    assign rsp_err   = r_rsp_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = ISSUE;
            ISSUE:   if (w_acc && w_issue_last) w_state_next = DRAIN;
            DRAIN:   if ((r_inflight == '0) && w_fifo_empty) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_col  <= '0;
            r_row  <= '0;
        end else if (w_start_acc) begin
            r_addr <= base_addr;
            r_col  <= '0;
            r_row  <= '0;
        end else if (w_acc) begin
            r_addr <= r_addr + 1'b1;
            if (r_col == c_last_col) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_acc, w_rsp_ok})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_err <= 1'b0;
        end else if (rsp_valid && (r_inflight == '0)) begin
            r_rsp_err <= 1'b1;
        end
    end

    // Output-side position tracks the stream, independent of the issue side.
    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_out_col <= '0;
            r_out_row <= '0;
        end else if (w_out_hs) begin
            if (r_out_col == c_last_col) begin
                r_out_col <= '0;
                r_out_row <= r_out_row + 1'b1;
            end else begin
                r_out_col <= r_out_col + 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_fifo_wr),
        .wr_data (rsp_data),
        .rd_en   (w_out_hs),
        .rd_data (out_data),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .count   (w_fifo_count)
    );

`ifdef READ_SEQ_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_bp_cycles;

    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_stall_cycles <= '0;
            r_bp_cycles    <= '0;
        end else begin
            if (rd_req && !rd_ready && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (out_valid && !out_ready && (r_bp_cycles != '1)) begin
                r_bp_cycles <= r_bp_cycles + 1'b1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign bp_cycles    = r_bp_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_input_read_sequencer.sv
// ============================================================================
// Module   : tb_input_read_sequencer
// Summary  : Self-checking bench for input_read_sequencer (4x2 image, depth 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_read_sequencer;

    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [11:0]  base_addr = '0;
    logic         busy, done, rd_req;
    logic [11:0]  rd_addr;
    logic         rd_ready = 1'b0;
    logic         rsp_valid = 1'b0;
    logic [107:0] rsp_data = '0;
    logic         out_valid;
    logic [107:0] out_data;
    logic         out_eol, out_last;
    logic         out_ready = 1'b0;
    logic         rsp_err;
`ifdef READ_SEQ_PERF_EN
    logic [31:0]  stall_cycles, bp_cycles;
`endif

    always #5 clk = ~clk;

    input_read_sequencer #(
        .ADD_SIZE   (12),
        .DATA_SIZE  (108),
        .IMG_W      (W),
        .IMG_H      (H),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ready  (rd_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_eol   (out_eol),
        .out_last  (out_last),
        .out_ready (out_ready),
        .rsp_err   (rsp_err)
`ifdef READ_SEQ_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .bp_cycles    (bp_cycles)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Environment: in-order memory responder plus frame-level reference model.
    typedef struct {
        logic [11:0] addr;
        int          due;
    } rsp_t;

    rsp_t        rq[$];
    int          cyc = 0, acc_cnt = 0, out_cnt = 0, done_cnt = 0;
    int          done_cyc = 0, last_hs_cyc = 0, last_due = 0, due = 0;
    logic [11:0] frame_base = '0, last_acc_addr = '0, exp_a;
    bit          rr_rand = 0, or_rand = 0, or_hold = 0, rsp_rand = 0, inj_rsp = 0;

    always @(negedge clk) begin
        cyc++;
        if (inj_rsp) begin
            rsp_valid = 1'b1;
            rsp_data  = 108'hBAD;
        end else if (rq.size() > 0 && rq[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = {9{rq[0].addr}};
            void'(rq.pop_front());
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
        end
        rd_ready  = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        out_ready = or_hold ? 1'b0 : (or_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        #1;
        if (rd_req === 1'b1 && rd_ready) begin
            check("rd_addr", rd_addr, 12'(frame_base + 12'(acc_cnt)));
            due = cyc + 1 + (rsp_rand ? int'($urandom_range(1, 3)) : 1);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            rq.push_back('{addr: rd_addr, due: due});
            last_acc_addr = rd_addr;
            acc_cnt++;
        end
        if (out_valid === 1'b1 && out_ready) begin
            exp_a = 12'(frame_base + 12'(out_cnt));
            check("out_data", out_data, {9{exp_a}});
            check("out_eol", out_eol, (out_cnt % W) == W - 1);
            check("out_last", out_last, out_cnt == N - 1);
            out_cnt++;
            last_hs_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic start_frame(input logic [11:0] base, input bit rr, input bit orr, input bit rsr);
        @(posedge clk); #2;
        rr_rand = rr; or_rand = orr; rsp_rand = rsr;
        frame_base = base; acc_cnt = 0; out_cnt = 0; done_cnt = 0;
        base_addr = base;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        base_addr = ~base;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done(input bit exp_err);
        int t = 0;
        while (done_cnt == 0 && t < 2000) begin
            @(posedge clk); #2;
            t++;
        end
        check("done_seen", done_cnt != 0, 1'b1);
        repeat (4) @(posedge clk);
        #2;
        check("done_count", done_cnt, 1);
        check("reads_issued", acc_cnt, N);
        check("words_out", out_cnt, N);
        check("done_latency", done_cyc - last_hs_cyc, 2);
        check("busy_after_done", busy, 1'b0);
        check("rsp_err_frame", rsp_err, exp_err);
    endtask

    typedef struct {
        logic [11:0] base;
        bit          rr;
        bit          orr;
        bit          rsr;
        bit          restart;
        logic [11:0] exp_last;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{12'h010, 1'b0, 1'b0, 1'b0, 1'b0, 12'h017};
        vecs[1] = '{12'hFFE, 1'b0, 1'b0, 1'b0, 1'b0, 12'h005};
        vecs[2] = '{12'h010, 1'b0, 1'b0, 1'b0, 1'b1, 12'h017};
        vecs[3] = '{12'h7FC, 1'b1, 1'b1, 1'b1, 1'b0, 12'h803};
        vecs[4] = '{12'hFFA, 1'b1, 1'b1, 1'b1, 1'b0, 12'h001};

        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_req", rd_req, 1'b0);
        check("rst_rd_addr", rd_addr, 12'h000);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 108'h0);
        check("rst_tags", {out_eol, out_last}, 2'b00);
        check("rst_rsp_err", rsp_err, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            start_frame(vecs[i].base, vecs[i].rr, vecs[i].orr, vecs[i].rsr);
            if (vecs[i].restart) begin
                repeat (2) @(posedge clk);
                #2;
                start = 1'b1;
                base_addr = 12'h300;
                @(posedge clk); #2;
                start = 1'b0;
            end
            wait_done(1'b0);
            check("last_addr", last_acc_addr, vecs[i].exp_last);
        end

        // Downstream stalled: credits must cap issue at the FIFO depth.
        or_hold = 1'b1;
        start_frame(12'h040, 1'b0, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #2;
        check("hold_reads", acc_cnt, 4);
        check("hold_rd_req", rd_req, 1'b0);
        check("hold_out_valid", out_valid, 1'b1);
        check("hold_words_out", out_cnt, 0);
`ifdef READ_SEQ_PERF_EN
        check("hold_bp_cycles", bp_cycles != 0, 1'b1);
`endif
        or_hold = 1'b0;
        wait_done(1'b0);

        // Reset in mid-frame after three accepted reads.
        begin
            int t = 0;
            start_frame(12'h100, 1'b0, 1'b0, 1'b0);
            while (acc_cnt < 3 && t < 100) begin
                @(posedge clk); #2;
                t++;
            end
            check("mid_rst_reached", acc_cnt >= 3, 1'b1);
            rst = 1'b1;
            @(posedge clk); #2;
            rq.delete();
            check("mid_rst_busy", busy, 1'b0);
            check("mid_rst_rd_req", rd_req, 1'b0);
            check("mid_rst_out_valid", out_valid, 1'b0);
            check("mid_rst_rd_addr", rd_addr, 12'h000);
            check("mid_rst_done", done, 1'b0);
            rst = 1'b0;
            repeat (3) @(posedge clk);
            #2;
            check("mid_rst_no_done", done_cnt, 0);
            start_frame(12'h100, 1'b0, 1'b0, 1'b0);
            wait_done(1'b0);
        end

        for (int i = 0; i < 6; i++) begin
            logic [11:0] b;
            b = 12'($urandom);
            start_frame(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_done(1'b0);
            check("rand_last_addr", last_acc_addr, 12'(b + 12'(N - 1)));
        end

        // Stray response while idle: sticky error, nothing enters the stream.
        @(posedge clk); #2;
        inj_rsp = 1'b1;
        @(posedge clk); #2;
        inj_rsp = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("stray_rsp_err", rsp_err, 1'b1);
        check("stray_out_valid", out_valid, 1'b0);
        start_frame(12'h020, 1'b0, 1'b0, 1'b0);
        wait_done(1'b1);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        check("rsp_err_cleared", rsp_err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

endmodule

`default_nettype wire
